iter_div: RTL and testbench

ITER_DIV -- requirements
Module: iter_div

---
 rtl/iter_div_pkg.sv | 23 ++
 rtl/div_step.sv | 30 +++
 rtl/iter_div.sv | 187 ++++++++++++++++++
 tb/tb_iter_div.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative divider: default width, FSM encoding, negate helper.
// No timing of its own; pure declarations.
// No flow control; consumed by iter_div and div_step.
package iter_div_pkg;

   // Default operand / quotient / remainder width
   localparam int DIV_WIDTH_DEF = 32;

   // FSM state encoding (kept as plain 2-bit constants for legacy tools)
   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOAD = 2'd1;
   localparam state_t ST_ITER = 2'd2;
   localparam state_t ST_FIX  = 2'd3;

   // Two's-complement negate at the widest legal width; callers truncate
   // to their own width, which yields the correct low-order result.
   function automatic logic [63:0] twos_neg(input logic [63:0] v);
      return ~v + 64'd1;
   endfunction

endpackage : iter_div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract the divisor.
// Purely combinational, zero latency.
// No flow control; evaluated every cycle the parent FSM iterates.
module div_step
   import iter_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] rem_i,   // partial remainder, always < dvs_i
   input  logic             bit_i,   // next dividend bit, MSB first
   input  logic [WIDTH-1:0] dvs_i,   // divisor magnitude
   output logic [WIDTH-1:0] rem_o,   // new partial remainder
   output logic             qbit_o   // quotient bit produced by this step
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The shifted remainder needs WIDTH+1 bits so an MSB=1 divisor in
   // unsigned mode cannot overflow it. Because rem_i < dvs_i, the shifted
   // value is below 2*dvs_i, so a WIDTH+1-bit difference is always in
   // range and its top bit is the sign of the trial subtraction.
   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {1'b0, dvs_i};

   // Non-negative difference: keep it and emit a 1; otherwise restore.
   assign qbit_o = ~diff[WIDTH];
   assign rem_o  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule : div_step

// File: rtl/iter_div.sv
// Iterative signed/unsigned restoring divider with divide-by-zero and overflow handling.
// Latency WIDTH+2 cycles start-to-done (2 cycles when the divisor is zero).
// Single-request handshake: start is taken only while ready=1; nothing is queued.
module iter_div
   import iter_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH);

   // Negate at this block's width using the shared package helper
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return WIDTH'(twos_neg(64'(v)));
   endfunction

   // FSM
   state_t state_q, state_d;

   // Operands as captured on acceptance (raw dividend also feeds div-by-zero)
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sop_q, sop_d;

   // Working registers for the iteration
   logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
   logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
   logic [CNT_W-1:0] cnt_q, cnt_d;   // remaining iterations minus one
   logic             qneg_q, qneg_d; // quotient must be negated at the end
   logic             rneg_q, rneg_d; // remainder must be negated at the end
   logic             dz_q, dz_d;     // divisor was zero

   // Held results presented between operations
   logic [WIDTH-1:0] quo_out_q;
   logic [WIDTH-1:0] rem_out_q;
   logic             dz_out_q;

   // Operand signs only matter in signed mode
   logic a_neg;
   logic b_neg;

   assign a_neg = sop_q & a_q[WIDTH-1];
   assign b_neg = sop_q & b_q[WIDTH-1];

   // Single restoring-step datapath shared by every iteration
   logic [WIDTH-1:0] step_rem;
   logic             step_qbit;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i  (rem_q),
      .bit_i  (quo_q[WIDTH-1]),
      .dvs_i  (dvs_q),
      .rem_o  (step_rem),
      .qbit_o (step_qbit)
   );

   // Sign-corrected final values, valid while in FIX. Most-negative / -1
   // needs no special case: the magnitude quotient is 2^(WIDTH-1) and the
   // operand signs agree, so it passes through as the most-negative value.
   logic [WIDTH-1:0] fix_quo;
   logic [WIDTH-1:0] fix_rem;

   assign fix_quo = dz_q ? '1  : (qneg_q ? neg_w(quo_q) : quo_q);
   assign fix_rem = dz_q ? a_q : (rneg_q ? neg_w(rem_q) : rem_q);

   // Next-state and working-register logic for the four-state sequence
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sop_d   = sop_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = dividend;
               b_d     = divisor;
               sop_d   = signed_op;
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            quo_d   = a_neg ? neg_w(a_q) : a_q;
            dvs_d   = b_neg ? neg_w(b_q) : b_q;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH - 1);
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = (b_q == '0);
            // A zero divisor skips the iterations entirely
            state_d = (b_q == '0) ? ST_FIX : ST_ITER;
         end

         ST_ITER: begin
            rem_d = step_rem;
            quo_d = {quo_q[WIDTH-2:0], step_qbit};
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_FIX: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and working registers; reset abandons any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sop_q   <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sop_q   <= sop_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

   // Capture the corrected result on leaving FIX so it holds afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         quo_out_q <= '0;
         rem_out_q <= '0;
         dz_out_q  <= 1'b0;
      end else if (state_q == ST_FIX) begin
         quo_out_q <= fix_quo;
         rem_out_q <= fix_rem;
         dz_out_q  <= dz_q;
      end
   end

   // The result is already visible during the done cycle; afterwards the
   // captured copy keeps it stable until the next operation completes.
   assign ready     = (state_q == ST_IDLE);
   assign done      = (state_q == ST_FIX);
   assign quotient  = done ? fix_quo : quo_out_q;
   assign remainder = done ? fix_rem : rem_out_q;
   assign div_zero  = done ? dz_q    : dz_out_q;

endmodule : iter_div

// File: tb/tb_iter_div.sv
// Self-checking bench for iter_div at WIDTH=32: directed vectors plus an arithmetic reference model.
// Outputs are compared on every falling edge; inputs change 1 time unit after the rising edge.
// Start is also held high continuously with random operands to exercise acceptance only in IDLE.
module tb_iter_div;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          signed_op;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          ready;
   logic          done;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_zero;

   always #5 clk = ~clk;

   iter_div #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .signed_op (signed_op),
      .dividend  (dividend),
      .divisor   (divisor),
      .ready     (ready),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } res_t;

   // Reference result from plain arithmetic
   function automatic res_t ref_div(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t res;
      int   sa;
      int   sb;
      res.dz = 1'b0;
      if (b == 0) begin
         res.q  = '1;
         res.r  = a;
         res.dz = 1'b1;
      end else if (!sop) begin
         res.q = a / b;
         res.r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         res.q = a;
         res.r = '0;
      end else begin
         sa    = $signed(a);
         sb    = $signed(b);
         res.q = 32'(sa / sb);
         res.r = 32'(sa % sb);
      end
      return res;
   endfunction

   // Behavioural model: an accepted request finishes a fixed number of
   // cycles later; results hold until the next completion; reset clears.
   int   m_left  = 0;
   logic m_valid = 1'b0;
   res_t m_held  = '0;
   res_t m_pend  = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_left  <= 0;
         m_held  <= '0;
         m_valid <= 1'b1;
      end else if (m_left == 0) begin
         if (start) begin
            m_pend <= ref_div(signed_op, dividend, divisor);
            m_left <= (divisor == 0) ? 2 : W + 2;
         end
      end else begin
         if (m_left == 1) m_held <= m_pend;
         m_left <= m_left - 1;
      end
   end

   // Compare process
   logic prev_done = 1'b0;
   int   n_done    = 0;

   always @(negedge clk) begin
      if (m_valid) begin
         chk("ready", ready, (m_left == 0));
         chk("done", done, (m_left == 1));
         chk("quotient",  quotient,  (m_left == 1) ? m_pend.q  : m_held.q);
         chk("remainder", remainder, (m_left == 1) ? m_pend.r  : m_held.r);
         chk("div_zero",  div_zero,  (m_left == 1) ? m_pend.dz : m_held.dz);
         if (done) begin
            chk("done_consecutive", prev_done, 1'b0);
            n_done <= n_done + 1;
         end
         prev_done <= done;
      end
   end

   // Wait for done with a cycle budget; c is the cycle index of done (1 = first cycle after accept)
   task automatic wait_done(output int c);
      bit got;
      c   = 0;
      got = 1'b0;
      while (c < 200 && !got) begin
         @(negedge clk);
         c++;
         if (done) got = 1'b1;
      end
   endtask

   task automatic run_op(input string name, input logic sop, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int elat);
      int c;
      @(posedge clk);
      #1;
      start     = 1'b1;
      signed_op = sop;
      dividend  = a;
      divisor   = b;
      @(posedge clk);
      #1;
      // Scramble operands after acceptance; they must not matter
      start     = 1'b0;
      signed_op = ~sop;
      dividend  = $urandom;
      divisor   = $urandom;
      wait_done(c);
      chk({name, "_latency"}, c, elat);
      chk({name, "_q"}, quotient, eq);
      chk({name, "_r"}, remainder, er);
      chk({name, "_dz"}, div_zero, edz);
   endtask

   typedef struct {
      string        name;
      logic         sop;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t pin;
      int   c;
      int   done_before;

      vecs[0] = '{"u_100_7",      1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
      vecs[1] = '{"s_m100_7",     1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 34};
      vecs[2] = '{"s_100_m7",     1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 34};
      vecs[3] = '{"u_msb_div",    1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 34};
      vecs[4] = '{"s_overflow",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34};
      vecs[5] = '{"u_div0",       1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 2};
      vecs[6] = '{"s_div0",       1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 2};
      vecs[7] = '{"s_m100_m7",    1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 34};
      vecs[8] = '{"u_7_100",      1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 34};

      rst       = 1'b1;
      start     = 1'b0;
      signed_op = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_ready", ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_quotient", quotient, '0);
      chk("rst_remainder", remainder, '0);
      chk("rst_div_zero", div_zero, 1'b0);

      // Pin the reference model against hand-computed values
      pin = ref_div(1'b1, 32'hFFFF_FF9C, 32'd7);
      chk("model_s_q", pin.q, 32'hFFFF_FFF2);
      chk("model_s_r", pin.r, 32'hFFFF_FFFE);
      pin = ref_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0000);
      chk("model_u_q", pin.q, 32'd1);
      chk("model_u_r", pin.r, 32'h7FFF_FFFF);

      // Directed vectors
      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].sop, vecs[i].a, vecs[i].b,
                vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);
      end

      // Abort with reset at iteration 10, then restart immediately
      @(posedge clk);
      #1;
      start     = 1'b1;
      signed_op = 1'b0;
      dividend  = 32'd100;
      divisor   = 32'd7;
      @(posedge clk);
      #1;
      start       = 1'b0;
      done_before = n_done;
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      start     = 1'b1;
      signed_op = 1'b0;
      dividend  = 32'd1000;
      divisor   = 32'd3;
      @(negedge clk);
      chk("abort_no_done", n_done, done_before);
      chk("abort_ready", ready, 1'b1);
      chk("abort_done", done, 1'b0);
      chk("abort_quotient", quotient, '0);
      chk("abort_remainder", remainder, '0);
      chk("abort_div_zero", div_zero, 1'b0);
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      wait_done(c);
      chk("restart_latency", c, 34);
      chk("restart_q", quotient, 32'd333);
      chk("restart_r", remainder, 32'd1);
      chk("restart_dz", div_zero, 1'b0);

      // start held high with random operands every cycle
      done_before = n_done;
      for (int i = 0; i < 700; i++) begin
         @(posedge clk);
         #1;
         start     = 1'b1;
         signed_op = 1'($urandom_range(0, 1));
         dividend  = $urandom;
         case ($urandom_range(0, 9))
            0:       divisor = '0;
            1: begin
               dividend = 32'h8000_0000;
               divisor  = 32'hFFFF_FFFF;
            end
            2:       divisor = 32'h8000_0000 | $urandom;
            default: divisor = $urandom >> $urandom_range(0, 31);
         endcase
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("random_ops_completed", (n_done - done_before) >= 15, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_iter_div
